alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 4..64).
- REQ-002 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
- REQ-003 SHALL have rst_n, input, 1; reset is asynchronous and active-low.
- REQ-004 SHALL have in_valid, input, 1, request strobe.
- REQ-005 SHALL have in_ready, output, 1, block can accept a request.
- REQ-006 SHALL have a, input, WIDTH, operand A.
- REQ-007 SHALL have b, input, WIDTH, operand B.
- REQ-008 SHALL have op, input, 3, operation select.
- REQ-009 SHALL have out_valid, output, 1, result available.
- REQ-010 SHALL have out_ready, input, 1, consumer accepts result.
- REQ-011 SHALL have result, output, WIDTH, low result word.
- REQ-012 SHALL have result_hi, output, WIDTH, high product word (MUL only, else 0).
- REQ-013 SHALL have zero, carry and overflow outputs, 1 bit each, status flags.

Function
- REQ-014 SHALL decode op as: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 MUL, 101 reserved.
- REQ-015 SHALL implement an FSM with states IDLE, MUL, DONE.
- REQ-016 SHALL assert in_ready only in IDLE; a request is accepted on an edge with in_valid && in_ready.
- REQ-017 SHALL latch a, b and op on acceptance; later input changes are ignored.
- REQ-018 SHALL, for non-MUL ops, go IDLE->DONE and assert out_valid on the edge after acceptance (latency 1).
- REQ-019 SHALL compute ADD/SUB modulo 2^WIDTH; SUB is a + ~b + 1.
- REQ-020 SHALL set carry to the adder carry-out for ADD/SUB and to 0 otherwise.
- REQ-021 SHALL set overflow to signed overflow for ADD/SUB and to 0 otherwise.
- REQ-022 SHALL, for SLT, return result = 1 when signed a<b (sign of a-b XOR overflow), else 0.
- REQ-023 SHALL return result = 0 with all flags 0 for the reserved op, and still complete with latency 1.
- REQ-024 SHALL set zero = (result == 0) for every op, including MUL (low word only).
- REQ-025 SHALL hold result, result_hi and flags stable in DONE while out_valid && !out_ready.
- REQ-026 SHALL return to IDLE on the edge where out_valid && out_ready; the next acceptance is possible one cycle later (no bypass).
- REQ-027 SHALL implement MUL as unsigned shift-add: IDLE->MUL on acceptance, one partial product per cycle for exactly WIDTH cycles, then ->DONE.
- REQ-028 SHALL assert out_valid for MUL on the (WIDTH+1)th edge after acceptance, with {result_hi,result} equal to the 2*WIDTH-bit product.

Reset
- REQ-029 SHALL, while rst_n is low, immediately force the state to IDLE, out_valid to 0, in_ready to 1, result/result_hi to 0 and all flags to 0.
- REQ-030 SHALL abandon any in-flight MUL or pending DONE result on reset, with no output produced after reset release.

Configuration
- REQ-031 SHALL compile the MUL datapath and state only when ALU_SEQ_MUL_EN is defined.
- REQ-032 SHALL, without ALU_SEQ_MUL_EN, treat op 011 exactly as reserved (REQ-023), tie result_hi to 0 and remove the MUL state.

Structure
- REQ-033 SHALL place the op encodings, FSM state encodings and WIDTH-independent constants in shared package alu_pkg.
- REQ-034 SHALL isolate the iterative multiplier in sub-module alu_seq_mul (start/done handshake, WIDTH parameter).

Verification (WIDTH=16)
- REQ-035 SHALL check ADD: a=0xFFFF, b=0x0001 -> result 0x0000, zero=1, carry=1, overflow=0, out_valid on the edge after acceptance.
- REQ-036 SHALL check SUB overflow: a=0x8000, b=0x0001 -> result 0x7FFF, overflow=1; SLT with a=0x8000, b=0x0001 -> result 0x0001.
- REQ-037 SHALL check MUL: a=0xFFFF, b=0xFFFF -> result_hi 0xFFFE, result 0x0001, out_valid exactly 17 edges after acceptance.
- REQ-038 SHALL check back-pressure: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; release -> IDLE, in_ready=1 next cycle.
- REQ-039 SHALL check reset mid-MUL: drop rst_n at cycle 8 of MUL -> out_valid=0, in_ready=1, outputs 0 immediately.
- REQ-040 SHALL check that with ALU_SEQ_MUL_EN undefined, op=011 -> result 0, result_hi 0, flags 0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes, FSM states and
// width-independent constants.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_MUL = 3'b011,
    OP_NOR = 3'b100,
    OP_RSV = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only present when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  // acc = {partial high word, unconsumed multiplier bits}; shifts right each step
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign product = {sum, acc[WIDTH-1:1]};
  // product is the post-step value, so it is complete in the same cycle done is high
  assign done    = busy && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc <= product;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle logic/arith ops and
// an optional iterative MUL enabled by the ALU_SEQ_MUL_EN macro.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  state_e state, state_nxt;
  logic   accept;

  logic [WIDTH:0]   add_s, sub_s;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, ovf_c, rsv_c, zero_c;

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic               is_mul, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign is_mul = (op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);

  // Evaluated on the live inputs; captured only on the acceptance edge.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    rsv_c   = 1'b0;
    case (op)
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_NOR: res_c = ~(a | b);
      OP_ADD: begin
        res_c   = add_s[WIDTH-1:0];
        carry_c = add_s[WIDTH];
        ovf_c   = add_v;
      end
      OP_SUB: begin
        res_c   = sub_s[WIDTH-1:0];
        carry_c = sub_s[WIDTH];
        ovf_c   = sub_v;
      end
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_v};
      default: rsv_c = 1'b1;
    endcase
  end

  // Reserved op reports all-zero status, including zero.
  assign zero_c = (res_c == '0) && !rsv_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          state_nxt = is_mul ? ST_MUL : ST_DONE;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL:  if (mul_done) state_nxt = ST_DONE;
`endif
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
    end else if (accept && !is_mul) begin
`else
    end else if (accept) begin
`endif
      result    <= res_c;
      result_hi <= '0;
      zero      <= zero_c;
      carry     <= carry_c;
      overflow  <= ovf_c;
`ifdef ALU_SEQ_MUL_EN
    end else if (state == ST_MUL && mul_done) begin
      result    <= mul_prod[WIDTH-1:0];
      result_hi <= mul_prod[2*WIDTH-1:WIDTH];
      zero      <= (mul_prod[WIDTH-1:0] == '0);
      carry     <= 1'b0;
      overflow  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): vector table plus handshake, MUL
// and reset sequences. MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result, result_hi;
  logic [2:0]  op;
  logic        zero, carry, overflow;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic        z, c, v;
  } vec_t;

  vec_t vt[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] r, input logic z, input logic c, input logic v);
    vec_t t;
    t.op = o; t.a = x; t.b = y; t.res = r; t.z = z; t.c = c; t.v = v;
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_result"},    result,    0);
    chk({tag, "_result_hi"}, result_hi, 0);
    chk({tag, "_flags"},     {zero, carry, overflow}, 0);
  endtask

  // Issue one request with out_ready=1; result must appear after the acceptance edge.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    chk({tag, "_in_ready_pre"}, in_ready, 1);
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_result"},    result,    v.res);
    chk({tag, "_result_hi"}, result_hi, 0);
    chk({tag, "_flags"},     {zero, carry, overflow}, {v.z, v.c, v.v});
    @(posedge clk);
  endtask

  initial begin
    logic [15:0] held;
    logic        bad;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;

    //            op      a        b        result   z  c  v
    vt.push_back(mk(3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0));
    vt.push_back(mk(3'b010, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1));
    vt.push_back(mk(3'b010, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0));
    vt.push_back(mk(3'b110, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1));
    vt.push_back(mk(3'b110, 16'h0005, 16'h0005, 16'h0000, 1, 1, 0));
    vt.push_back(mk(3'b110, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0));
    vt.push_back(mk(3'b111, 16'h8000, 16'h0001, 16'h0001, 0, 0, 0));
    vt.push_back(mk(3'b111, 16'h0001, 16'h8000, 16'h0000, 1, 0, 0));
    vt.push_back(mk(3'b111, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0));
    vt.push_back(mk(3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0));
    vt.push_back(mk(3'b000, 16'h00FF, 16'hFF00, 16'h0000, 1, 0, 0));
    vt.push_back(mk(3'b001, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0));
    vt.push_back(mk(3'b100, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0));
    vt.push_back(mk(3'b100, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0));
    vt.push_back(mk(3'b101, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0));
`ifndef ALU_SEQ_MUL_EN
    vt.push_back(mk(3'b011, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0));
`endif

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Back-pressure: result held, inputs ignored, no new acceptance until release.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; op = 3'b010; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; op = 3'b001;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || in_ready || result !== 16'h2345 || {zero, carry, overflow} !== 3'b000)
        bad = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_hold", bad, 0);
    chk("bp_result", result, 16'h2345);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

`ifdef ALU_SEQ_MUL_EN
    // MUL latency: out_valid after the 17th edge counting the acceptance edge.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; op = 3'b011; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0;
    bad = out_valid;
    for (int k = 2; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("mul_early_valid", bad, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mul_out_valid", out_valid, 1);
    chk("mul_result", result, 16'h0001);
    chk("mul_result_hi", result_hi, 16'hFFFE);
    chk("mul_flags", {zero, carry, overflow}, 3'b000);
    @(posedge clk);

    @(negedge clk);
    a = 16'h0000; b = 16'h1234; op = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mul0_out_valid", out_valid, 1);
    chk("mul0_result", {result_hi, result}, 32'h0);
    chk("mul0_zero", zero, 1);
    @(posedge clk);

    // Reset asynchronously 8 cycles into a MUL; earlier result is nonzero.
    run_vec(mk(3'b001, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0), 100);
    @(negedge clk);
    a = 16'h1234; b = 16'h0010; op = 3'b011; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mul");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("rst_mul_no_output", bad, 0);
`endif

    // Reset while a result is pending in DONE.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; op = 3'b001; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    held = result;
    chk("pend_result", held, 16'h0FFF);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("rst_done");
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad = 1'b1;
    end
    chk("rst_done_no_output", bad, 0);

    // Block still operational after reset.
    run_vec(mk(3'b010, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0), 200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
